// File: rtl/mbf_band_merger.sv
// Aligns the independent LPF (y) and HPF (z) sample streams from the MBF core into
// indexed {y,z} pairs on a valid/ready output, counting pairs up to one frame.
module mbf_band_merger #(
    parameter int unsigned DW        = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned N_SAMPLES = 527
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            y_valid,
    input  logic [DW-1:0]   y,
    input  logic            z_valid,
    input  logic [DW-1:0]   z,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [2*DW-1:0] out_data,
    output logic [9:0]      out_index,
    output logic            done,
    output logic            overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = 10;
    localparam int unsigned NB = 2;

    logic [DW-1:0]   mem_q [NB][DEPTH];
    logic [DW-1:0]   mem_d [NB][DEPTH];
    logic [AW-1:0]   wr_q [NB];
    logic [AW-1:0]   wr_d [NB];
    logic [AW-1:0]   rd_q [NB];
    logic [AW-1:0]   rd_d [NB];
    logic [CW-1:0]   cnt_q [NB];
    logic [CW-1:0]   cnt_d [NB];
    logic [IW-1:0]   pair_q, pair_d;
    logic [IW-1:0]   index_q, index_d;
    logic [2*DW-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;

    logic            in_valid [NB];
    logic [DW-1:0]   in_data [NB];
    logic            push_ok [NB];
    logic            xfer, last_xfer, pop;

    // Band 0 is y (upper half of the pair), band 1 is z.
    always_comb begin
        in_valid[0] = y_valid;
        in_data[0]  = y;
        in_valid[1] = z_valid;
        in_data[1]  = z;

        xfer      = valid_q && out_ready;
        last_xfer = xfer && (index_q == IW'(N_SAMPLES - 1));
        // The final transfer of a frame must not pull a pair beyond the frame.
        pop = (cnt_q[0] != '0) && (cnt_q[1] != '0) && (!valid_q || out_ready)
              && !done_q && !last_xfer;

        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;

        for (int b = 0; b < NB; b++) begin
            push_ok[b] = 1'b0;
            if (in_valid[b] && !done_q) begin
                // A full FIFO still accepts the push when its head leaves on this edge.
                if ((cnt_q[b] == CW'(DEPTH)) && !pop) begin
                    overflow_d = 1'b1;
                end else begin
                    push_ok[b]              = 1'b1;
                    mem_d[b][wr_q[b]]       = in_data[b];
                    wr_d[b]                 = wr_q[b] + AW'(1);
                end
            end
            if (pop) begin
                rd_d[b] = rd_q[b] + AW'(1);
            end
            cnt_d[b] = cnt_q[b] + CW'(push_ok[b]) - CW'(pop);
        end

        pair_d  = xfer ? (pair_q + IW'(1)) : pair_q;
        done_d  = done_q || last_xfer;
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        if (pop) begin
            valid_d = 1'b1;
            data_d  = {mem_q[0][rd_q[0]], mem_q[1][rd_q[1]]};
            index_d = pair_d;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                wr_q[b]  <= '0;
                rd_q[b]  <= '0;
                cnt_q[b] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            pair_q     <= '0;
            index_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            pair_q     <= pair_d;
            index_q    <= index_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mbf_band_merger.sv
// Directed self-checking bench for mbf_band_merger with hand-derived expectations.
module tb_mbf_band_merger;

    logic        clk = 1'b0;
    logic        reset;
    logic        y_valid;
    logic [7:0]  y;
    logic        z_valid;
    logic [7:0]  z;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [9:0]  out_index;
    logic        done;
    logic        overflow;

    int checks = 0;
    int fails  = 0;

    mbf_band_merger #(.DW(8), .DEPTH(8), .N_SAMPLES(527)) dut (
        .clk       (clk),
        .reset     (reset),
        .y_valid   (y_valid),
        .y         (y),
        .z_valid   (z_valid),
        .z         (z),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        y_valid = 1'b0;
        z_valid = 1'b0;
        y       = 8'h00;
        z       = 8'h00;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        reset     = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_index !== 10'd0 ||
            done !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset: got v=%b d=%h i=%0d done=%b ovf=%b expected all zero",
                     out_valid, out_data, out_index, done, overflow);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_lockstep();
        logic [7:0] ey, ez;
        test_reset();
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                y_valid = 1'b1; z_valid = 1'b1;
                y = 8'(k); z = 8'hFF - 8'(k);
            end else begin
                idle_inputs();
            end
            step();
            checks++;
            if (k >= 1 && k <= 10) begin
                ey = 8'(k - 1);
                ez = 8'hFF - ey;
                if (out_valid !== 1'b1 || out_data !== {ey, ez} || out_index !== 10'(k - 1)
                    || overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL lockstep k=%0d: got v=%b d=%h i=%0d ovf=%b expected v=1 d=%h i=%0d ovf=0",
                             k, out_valid, out_data, out_index, overflow, {ey, ez}, k - 1);
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL lockstep_idle k=%0d: got v=%b expected v=0", k, out_valid);
            end
        end
    endtask

    task automatic test_skewed();
        test_reset();
        for (int k = 0; k < 5; k++) begin
            y_valid = 1'b1; y = 8'(10 + k);
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL skew_y_only k=%0d: got v=%b expected v=0", k, out_valid);
            end
        end
        idle_inputs();
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                z_valid = 1'b1; z = 8'(20 + k);
            end else begin
                idle_inputs();
            end
            step();
            checks++;
            if (k >= 1 && k <= 5) begin
                if (out_valid !== 1'b1 || out_data !== {8'(10 + k - 1), 8'(20 + k - 1)} ||
                    out_index !== 10'(k - 1)) begin
                    fails++;
                    $display("FAIL skew_pair k=%0d: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d",
                             k, out_valid, out_data, out_index,
                             {8'(10 + k - 1), 8'(20 + k - 1)}, k - 1);
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL skew_idle k=%0d: got v=%b expected v=0", k, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        test_reset();
        for (int k = 0; k < 20; k++) begin
            if (k <= 10) begin
                y_valid = 1'b1; z_valid = 1'b1;
                y = 8'(k); z = 8'(100 + k);
            end else begin
                idle_inputs();
            end
            out_ready = (k >= 3 && k <= 10) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (k >= 2 && k <= 10) begin
                // Stalled: pair 1 held stable, overflow only after the ninth extra push.
                if (out_valid !== 1'b1 || out_data !== {8'd1, 8'd101} || out_index !== 10'd1 ||
                    overflow !== (k == 10)) begin
                    fails++;
                    $display("FAIL bp_hold k=%0d: got v=%b d=%h i=%0d ovf=%b expected v=1 d=0165 i=1 ovf=%b",
                             k, out_valid, out_data, out_index, overflow, (k == 10));
                end
            end else if (k >= 11 && k <= 18) begin
                if (out_valid !== 1'b1 || out_data !== {8'(k - 9), 8'(100 + k - 9)} ||
                    out_index !== 10'(k - 9) || overflow !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_drain k=%0d: got v=%b d=%h i=%0d ovf=%b expected v=1 d=%h i=%0d ovf=1",
                             k, out_valid, out_data, out_index, overflow,
                             {8'(k - 9), 8'(100 + k - 9)}, k - 9);
                end
            end else if (k == 19 && out_valid !== 1'b0) begin
                fails++;
                $display("FAIL bp_empty: got v=%b expected v=0", out_valid);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_full_pop();
        test_reset();
        for (int k = 0; k < 20; k++) begin
            if (k <= 10) begin
                y_valid = 1'b1; z_valid = 1'b1;
                y = 8'(k); z = 8'(8'h80 + k);
            end else begin
                idle_inputs();
            end
            out_ready = (k <= 8 || k == 10) ? 1'b0 : 1'b1;
            step();
            if (k == 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 16'h0080 || overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL full_fill: got v=%b d=%h ovf=%b expected v=1 d=0080 ovf=0",
                             out_valid, out_data, overflow);
                end
            end else if (k == 9) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 16'h0181 || overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL full_push_pop: got v=%b d=%h ovf=%b expected v=1 d=0181 ovf=0",
                             out_valid, out_data, overflow);
                end
            end else if (k == 10) begin
                checks++;
                if (overflow !== 1'b1 || out_data !== 16'h0181) begin
                    fails++;
                    $display("FAIL full_still_8: got d=%h ovf=%b expected d=0181 ovf=1",
                             out_data, overflow);
                end
            end else if (k >= 11 && k <= 18) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== {8'(k - 9), 8'(8'h80 + k - 9)} ||
                    out_index !== 10'(k - 9)) begin
                    fails++;
                    $display("FAIL full_drain k=%0d: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d",
                             k, out_valid, out_data, out_index,
                             {8'(k - 9), 8'(8'h80 + k - 9)}, k - 9);
                end
            end else if (k == 19) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL full_empty: got v=%b expected v=0", out_valid);
                end
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_frame_end();
        int xfers;
        logic [7:0] ey;
        xfers = 0;
        test_reset();
        for (int k = 0; k < 550; k++) begin
            y_valid = 1'b1; z_valid = 1'b1;
            y = 8'(k); z = 8'hFF - 8'(k);
            step();
            if (out_valid === 1'b1) xfers++;
            checks++;
            if (k >= 1 && k <= 527) begin
                ey = 8'(k - 1);
                if (out_valid !== 1'b1 || out_index !== 10'(k - 1) ||
                    out_data !== {ey, 8'hFF - ey} || done !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_pair k=%0d: got v=%b d=%h i=%0d done=%b expected v=1 d=%h i=%0d done=0",
                             k, out_valid, out_data, out_index, done, {ey, 8'hFF - ey}, k - 1);
                end
            end else if (k >= 528) begin
                if (out_valid !== 1'b0 || done !== 1'b1 || overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_done k=%0d: got v=%b done=%b ovf=%b expected v=0 done=1 ovf=0",
                             k, out_valid, done, overflow);
                end
            end
        end
        idle_inputs();
        checks++;
        if (xfers != 527) begin
            fails++;
            $display("FAIL frame_count: got %0d transfers expected 527", xfers);
        end
    endtask

    task automatic test_async_reset();
        test_reset();
        for (int k = 0; k < 102; k++) begin
            y_valid = 1'b1; z_valid = 1'b1;
            y = 8'(k); z = 8'hFF - 8'(k);
            step();
        end
        checks++;
        if (out_valid !== 1'b1 || out_index !== 10'd100) begin
            fails++;
            $display("FAIL areset_pre: got v=%b i=%0d expected v=1 i=100", out_valid, out_index);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_index !== 10'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL areset_clear: got v=%b d=%h i=%0d done=%b expected all zero",
                     out_valid, out_data, out_index, done);
        end
        idle_inputs();
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            y_valid = 1'b1; z_valid = 1'b1;
            y = 8'(8'h40 + k); z = 8'(8'h50 + k);
            step();
            if (k >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== 10'(k - 1) ||
                    out_data !== {8'(8'h40 + k - 1), 8'(8'h50 + k - 1)} || done !== 1'b0) begin
                    fails++;
                    $display("FAIL areset_restart k=%0d: got v=%b d=%h i=%0d done=%b expected v=1 d=%h i=%0d done=0",
                             k, out_valid, out_data, out_index, done,
                             {8'(8'h40 + k - 1), 8'(8'h50 + k - 1)}, k - 1);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_lockstep();
        test_skewed();
        test_backpressure();
        test_full_pop();
        test_frame_end();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
